mux_scan_sampler: RTL
=====================

// Module: mux_scan_sampler
// PURPOSE
//   Sequencer that sits around a 4:1 mux. Drives the mux select input through every channel
//   and samples the mux output back into a parallel word.
//   Upstream role: generates sel. Downstream role: consumes the mux out bit.
//   Each channel is held for a programmable dwell so the mux path settles before sampling.
//   Result is one N_CH-bit word per scan, flagged with a one-cycle valid pulse.
// PARAMETERS
//   N_CH   4  number of mux channels scanned; power of two, >= 2
//   SEL_W  2  select width; must equal log2(N_CH)
//   DWELL  2  cycles each channel is held before sampling; >= 1
//   CNT_W  2  dwell counter width; must satisfy 2**CNT_W >= DWELL
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      scan request; sampled only in IDLE
//   mux_out   in   1      output bit of the external mux
//   sel       out  SEL_W  select bus to the external mux
//   busy      out  1      high while a scan is in progress
//   data_out  out  N_CH   last completed scan; bit i = mux_out sampled with sel==i
//   valid     out  1      single-cycle pulse when data_out updates
// BEHAVIOUR
//   Reset (rst_n low, async) forces:
//     - state=IDLE
//     - sel=0, busy=0, data_out=0, valid=0
//     - dwell counter=0, shadow register=0
//   FSM, two states:
//     - IDLE: sel held at 0. start=1 at edge k -> SCAN, busy=1, sel=0, cnt=0, all after edge k.
//     - SCAN: each edge with cnt<DWELL-1 increments cnt.
//     - SCAN: on the edge where cnt==DWELL-1, shadow[sel]<=mux_out (the value present before that edge).
//     - SCAN, sel<N_CH-1: sel<=sel+1, cnt<=0.
//     - SCAN, sel==N_CH-1: data_out<={mux_out,shadow[N_CH-2:0]}, valid<=1, busy<=0, sel<=0, state<=IDLE.
//   Timing:
//     - Channel i is sampled at edge k+(i+1)*DWELL.
//     - valid is high for exactly the one cycle after edge k+N_CH*DWELL.
//     - Latency from start to data_out/valid is N_CH*DWELL cycles.
//   Boundary conditions:
//     - start while busy is ignored; no queuing.
//     - start held high continuously: a new scan begins on the edge after the valid edge, since IDLE lasts one cycle.
//     - DWELL=1: sel advances every cycle and each sample is taken on the edge after sel changes.
//     - sel wraps N_CH-1 -> 0 only through IDLE; sel never exceeds N_CH-1.
//     - valid and busy are never both high.
//     - data_out holds its value between scans and changes only on the valid edge.
//     - A partial scan never reaches data_out.
//     - Reset mid-scan: scan is aborted, all outputs take their reset values, partial samples are discarded.
//   All outputs are registered; no combinational path from any input to any output.
// CONFIGURATION
//   SCAN_AUTORUN_EN
//     - Defined: free-running mode; start is ignored.
//     - Defined: the first scan begins on the first edge after rst_n deasserts; IDLE lasts one cycle.
//     - Defined: after the final capture the block re-enters SCAN directly (sel=0, cnt=0) and busy stays 1.
//     - Defined: valid pulses every N_CH*DWELL cycles.
//     - Undefined: one-shot operation triggered by start, exactly as described above.
// TESTING
//   Bench instantiates the existing 4:1 mux with this block driving sel and consuming out. Defaults N_CH=4, DWELL=2.
//   1. in=4'b0101, single start pulse -> sel steps 0,1,2,3, each for 2 cycles; valid pulses once 8 cycles after start; data_out=4'b0101.
//   2. in=4'b0011, start pulse; after valid, in=4'b1100 with no start -> data_out=4'b0011 and stays stable; no further valid.
//   3. start pulsed again in cycle 3 of a scan -> ignored; exactly one valid; busy high for 8 cycles, then low.
//   4. rst_n low in cycle 5 of a scan with in=4'b1111 -> sel=0, busy=0, valid=0 and data_out=0 immediately (async); next scan returns 4'b1111.
//   5. start held high, in=4'b1010 -> valid every 9 cycles, data_out=4'b1010 each time.
//   6. DWELL=1 build, plus SCAN_AUTORUN_EN build, in=4'b0110 -> valid every 4 cycles from reset release, data_out=4'b0110.

Source files
------------

// File: rtl/mux_scan_sampler_if.sv
// Bundle of the signals between mux_scan_sampler and its environment.
// The sampler side (master) generates sel and reports results.
// The environment side (slave) supplies the start request and the external mux output bit.
//
// Handshake: there is no backpressure on the result.
//   - valid is a one-cycle pulse that marks a new data_out word.
//   - start is a level that the sampler looks at only while idle.
//   - busy reports that a scan is in progress; start seen while busy is dropped.
interface mux_scan_sampler_if #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
);
    logic             start;
    logic             mux_out;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic [N_CH-1:0]  data_out;
    logic             valid;

    // Sampler side.
    modport master (
        input  start,
        input  mux_out,
        output sel,
        output busy,
        output data_out,
        output valid
    );

    // Environment side: request source and external mux.
    modport slave (
        output start,
        output mux_out,
        input  sel,
        input  busy,
        input  data_out,
        input  valid
    );
endinterface

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: steps an external N_CH:1 mux through all channels.
// Each channel is held for DWELL cycles.
// At the end of each dwell the mux output bit is captured into a shadow word.
// After the last channel the completed word is published on data_out with a one-cycle valid pulse.
//
// Optional build macro SCAN_AUTORUN_EN:
//   - The block runs free and ignores start.
//   - A scan follows the previous one back to back.
//   - busy stays high after the first scan has begun.
// Without the macro, a scan is launched by start while idle.
//
// Every output is a flop, so there is no combinational path from any input to any output.
// state_dbg exposes the FSM state (0 = IDLE, 1 = SCAN).
module mux_scan_sampler #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 2,
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_scan_sampler_if.master    bus,
    output logic                  state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    // Holds the partial scan.
    // It only reaches data_out when the last channel has been captured.
    logic [N_CH-1:0]  shadow;

    assign state_dbg = state;

    // Sequencer.
    // In SCAN, the channel in sel is held until its dwell expires.
    // The mux bit present before that edge is captured.
    // Then sel advances, or the scan closes on the last channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            shadow       <= '0;
            bus.sel      <= '0;
            bus.busy     <= 1'b0;
            bus.data_out <= '0;
            bus.valid    <= 1'b0;
        end else begin
            // valid is a pulse: cleared on every edge unless a scan completes below.
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.sel <= '0;
                    cnt     <= '0;
`ifdef SCAN_AUTORUN_EN
                    // Free-running: IDLE lasts exactly one cycle after reset.
                    state    <= SCAN;
                    bus.busy <= 1'b1;
`else
                    if (bus.start) begin
                        state    <= SCAN;
                        bus.busy <= 1'b1;
                    end
`endif
                end
                SCAN: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        // Dwell expired: the mux path for channel sel has settled.
                        shadow[bus.sel] <= bus.mux_out;
                        cnt             <= '0;
                        if (bus.sel != SEL_LAST) begin
                            bus.sel <= bus.sel + SEL_W'(1);
                        end else begin
                            // The last channel goes straight to data_out alongside the shadow bits.
                            bus.data_out <= {bus.mux_out, shadow[N_CH-2:0]};
                            bus.valid    <= 1'b1;
                            bus.sel      <= '0;
`ifdef SCAN_AUTORUN_EN
                            // Re-enter SCAN directly; busy never drops.
                            state    <= SCAN;
                            bus.busy <= 1'b1;
`else
                            state    <= IDLE;
                            bus.busy <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.sel  <= '0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule
